// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for mem_access_unit and its lane aligner.
package mem_access_unit_pkg;

  // Access size encoding on width_in
  typedef enum logic [1:0] {
    WidthByte  = 2'd0,
    WidthHalf  = 2'd1,
    WidthWord  = 2'd2,
    WidthDword = 2'd3
  } width_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBeat0 = 2'd1,
    StBeat1 = 2'd2,
    StHold  = 2'd3
  } state_e;

  localparam int unsigned MaxLanes = 8;

  // Byte enables over two consecutive bus words; the upper half is the second beat.
  function automatic logic [2*MaxLanes-1:0] lane_mask(input logic [1:0] width,
                                                      input logic [2:0] offset);
    logic [2*MaxLanes-1:0] ones;
    ones = (16'd1 << (5'd1 << width)) - 16'd1;
    return ones << offset;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory bus between mem_access_unit (master) and the memory side (slave).
interface mem_access_unit_if #(
  parameter int unsigned XLEN = 64
);
  localparam int unsigned NB = XLEN / 8;

  logic            bus_req_out;
  logic            bus_we_out;
  logic [XLEN-1:0] bus_addr_out;
  logic [XLEN-1:0] bus_wdata_out;
  logic [NB-1:0]   bus_mask_out;
  logic            bus_ack_in;
  logic [XLEN-1:0] bus_rdata_in;

  modport master (
    output bus_req_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_mask_out,
    input  bus_ack_in, bus_rdata_in
  );

  modport slave (
    input  bus_req_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_mask_out,
    output bus_ack_in, bus_rdata_in
  );
endinterface

// File: rtl/mem_lane_align.sv
// Load extraction: shift the two-beat read data down to the access offset and
// sign- or zero-extend the selected bytes to XLEN.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]             lo_data,
  input  logic [XLEN-1:0]             hi_data,
  input  logic [$clog2(XLEN/8)-1:0]   offset,
  input  logic [1:0]                  width,
  input  logic                        zero_extend,
  output logic [XLEN-1:0]             result
);
  localparam int unsigned IdxW = $clog2(2 * XLEN);

  logic [2*XLEN-1:0] shifted;
  logic              sign;
  int unsigned       nbits;

  // Align, then replicate the fill bit above the access size
  always_comb begin
    shifted = {hi_data, lo_data} >> {offset, 3'b000};
    nbits   = 32'd8 << width;
    sign    = ~zero_extend & shifted[IdxW'(nbits - 1)];
    result  = shifted[XLEN-1:0];
    for (int i = 0; i < XLEN; i++) begin
      if (i >= int'(nbits)) result[i] = sign;
    end
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: issues one or two bus beats per memory op and registers the
// writeback. Define MEM_MISALIGNED_SPLIT_EN to split word-spanning accesses into
// two beats; otherwise they are reported as misaligned without a bus request.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RD_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic              read_in,
  input  logic              write_in,
  input  logic [1:0]        width_in,
  input  logic              zero_extend_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              rd_write_in,
  input  logic [XLEN-1:0]   addr_in,
  input  logic [XLEN-1:0]   wdata_in,
  output logic              busy_out,
  output logic              valid_out,
  output logic              rd_write_out,
  output logic              misaligned_out,
  output logic [RD_W-1:0]   rd_out,
  output logic [XLEN-1:0]   rd_value_out,
  mem_access_unit_if.master bus
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OffW = $clog2(NB);
`ifdef MEM_MISALIGNED_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              is_load_q, span_q, kill_q, zext_q, rd_write_q;
  logic [1:0]        width_q;
  logic [RD_W-1:0]   rd_q;
  logic [OffW-1:0]   off_q;
  logic [XLEN-1:0]   base_q, rdata0_q, rdata1_q;
  logic [2*XLEN-1:0] wdata_q;
  logic [2*NB-1:0]   mask_q;

  logic [2*MaxLanes-1:0] mask_all;
  logic [2*NB-1:0]       mask_req;
  logic                  is_mem, spans, reject, accept, start, kill_now, done;
  logic [XLEN-1:0]       lo_data, hi_data, load_result;

  // Request decode in the accept cycle
  always_comb begin
    mask_all = lane_mask(width_in, 3'(addr_in[OffW-1:0]));
    mask_req = mask_all[2*NB-1:0];
    is_mem   = read_in | write_in;
    spans    = |mask_req[2*NB-1:NB];
    reject   = spans & ~SplitEn;
    accept   = valid_in & (state_q == StIdle) & ~stall_in & ~flush_in;
    start    = accept & is_mem & ~reject;
    busy_out = (state_q != StIdle) | (accept & is_mem);
    kill_now = kill_q | flush_in;
  end

  // Next state and bus drive; bus fields are held from registers so they stay stable
  always_comb begin
    state_d           = state_q;
    done              = 1'b0;
    bus.bus_req_out   = 1'b0;
    bus.bus_we_out    = 1'b0;
    bus.bus_addr_out  = '0;
    bus.bus_wdata_out = '0;
    bus.bus_mask_out  = '0;
    unique case (state_q)
      StIdle: if (start) state_d = StBeat0;
      StBeat0: begin
        bus.bus_req_out   = 1'b1;
        bus.bus_we_out    = ~is_load_q;
        bus.bus_addr_out  = base_q;
        bus.bus_wdata_out = wdata_q[XLEN-1:0];
        bus.bus_mask_out  = mask_q[NB-1:0];
        if (bus.bus_ack_in) begin
          if (span_q && SplitEn && !kill_now) begin
            state_d = StBeat1;
          end else begin
            done    = 1'b1;
            state_d = stall_in ? StHold : StIdle;
          end
        end
      end
      StBeat1: begin
        bus.bus_req_out   = 1'b1;
        bus.bus_we_out    = ~is_load_q;
        bus.bus_addr_out  = base_q + XLEN'(NB);
        bus.bus_wdata_out = wdata_q[2*XLEN-1:XLEN];
        bus.bus_mask_out  = mask_q[2*NB-1:NB];
        if (bus.bus_ack_in) begin
          done    = 1'b1;
          state_d = stall_in ? StHold : StIdle;
        end
      end
      StHold: if (!stall_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Capture the accepted op and the read data of each beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load_q  <= 1'b0;
      span_q     <= 1'b0;
      kill_q     <= 1'b0;
      zext_q     <= 1'b0;
      rd_write_q <= 1'b0;
      width_q    <= 2'd0;
      rd_q       <= '0;
      off_q      <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      if (start) begin
        is_load_q  <= read_in;
        span_q     <= spans;
        kill_q     <= 1'b0;
        zext_q     <= zero_extend_in;
        rd_write_q <= rd_write_in;
        width_q    <= width_in;
        rd_q       <= rd_in;
        off_q      <= addr_in[OffW-1:0];
        base_q     <= {addr_in[XLEN-1:OffW], {OffW{1'b0}}};
        wdata_q    <= {{XLEN{1'b0}}, wdata_in} << {addr_in[OffW-1:0], 3'b000};
        mask_q     <= mask_req;
      end else if (state_q != StIdle && flush_in) begin
        kill_q <= 1'b1;
      end
      if (state_q == StBeat0 && bus.bus_ack_in) rdata0_q <= bus.bus_rdata_in;
      if (state_q == StBeat1 && bus.bus_ack_in) rdata1_q <= bus.bus_rdata_in;
    end
  end

  // Live read data in the ack cycle, captured data once in HOLD
  assign lo_data = (state_q == StBeat0) ? bus.bus_rdata_in : rdata0_q;
  assign hi_data = (state_q == StBeat1) ? bus.bus_rdata_in : rdata1_q;

  mem_lane_align #(
    .XLEN(XLEN)
  ) u_align (
    .lo_data    (lo_data),
    .hi_data    (hi_data),
    .offset     (off_q),
    .width      (width_q),
    .zero_extend(zext_q),
    .result     (load_result)
  );

  // Writeback registers; they hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out      <= 1'b0;
      rd_write_out   <= 1'b0;
      misaligned_out <= 1'b0;
      rd_out         <= '0;
      rd_value_out   <= '0;
    end else if (!stall_in) begin
      valid_out      <= 1'b0;
      rd_write_out   <= 1'b0;
      misaligned_out <= 1'b0;
      if (accept && !is_mem) begin
        valid_out    <= 1'b1;
        rd_write_out <= rd_write_in;
        rd_out       <= rd_in;
        rd_value_out <= addr_in;
      end else if (accept && reject) begin
        valid_out      <= 1'b1;
        misaligned_out <= 1'b1;
        rd_out         <= rd_in;
      end else if (done || state_q == StHold) begin
        valid_out    <= ~kill_now;
        rd_write_out <= is_load_q & rd_write_q & ~kill_now;
        rd_out       <= rd_q;
        rd_value_out <= is_load_q ? load_result : '0;
      end
    end
  end
endmodule
